// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring counter for legality and sequencing, and encodes its phase.
// Optional macro RING_AUTO_RESYNC_EN lets FAULT recover on two consecutive in-sequence samples.
module ring_phase_monitor #(
  parameter int unsigned word_size = 8,
  parameter int unsigned idx_width = 3,
  parameter int unsigned rev_width = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [word_size-1:0] ring_in,
  input  logic                 ring_step,
  input  logic                 ring_reset,
  input  logic                 err_clear,
  output logic [idx_width-1:0] phase_idx,
  output logic                 phase_valid,
  output logic                 wrap_pulse,
  output logic [rev_width-1:0] rev_count,
  output logic                 onehot_err,
  output logic                 seq_err
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t               state;
  logic [word_size-1:0] prev_ring;
  logic                 prev_step;

  logic                 legal_c;
  logic [idx_width-1:0] set_idx_c;
  logic [word_size-1:0] expected_c;

  function automatic logic [word_size-1:0] rotl(input logic [word_size-1:0] v);
    return {v[word_size-2:0], v[word_size-1]};
  endfunction

  // Legality, bit index of the active bit, and the value the ring should show now.
  always_comb begin
    legal_c    = ($countones(ring_in) == 1);
    set_idx_c  = '0;
    expected_c = prev_step ? rotl(prev_ring) : prev_ring;
    for (int unsigned i = 0; i < word_size; i++) begin
      if (ring_in[i]) set_idx_c = idx_width'(i);
    end
  end

`ifdef RING_AUTO_RESYNC_EN
  logic                 rs_armed;
  logic [word_size-1:0] rs_ring;
  logic                 rs_step;
  logic [word_size-1:0] rs_expected_c;

  always_comb begin
    rs_expected_c = rs_step ? rotl(rs_ring) : rs_ring;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_SYNC;
      prev_ring   <= '0;
      prev_step   <= 1'b0;
      phase_idx   <= '0;
      phase_valid <= 1'b0;
      wrap_pulse  <= 1'b0;
      rev_count   <= '0;
      onehot_err  <= 1'b0;
      seq_err     <= 1'b0;
`ifdef RING_AUTO_RESYNC_EN
      rs_armed    <= 1'b0;
      rs_ring     <= '0;
      rs_step     <= 1'b0;
`endif
    end else begin
      wrap_pulse <= 1'b0;
      // Clear first so a same-cycle error set below takes precedence.
      if (err_clear) begin
        onehot_err <= 1'b0;
        seq_err    <= 1'b0;
      end
      if (state != ST_FAULT) begin
        prev_ring <= ring_in;
        prev_step <= ring_step;
`ifdef RING_AUTO_RESYNC_EN
        rs_armed  <= 1'b0;
`endif
      end

      case (state)
        ST_SYNC: begin
          if (legal_c) begin
            state       <= ST_TRACK;
            phase_idx   <= set_idx_c;
            phase_valid <= 1'b1;
          end else begin
            phase_valid <= 1'b0;
          end
        end

        ST_TRACK: begin
          if (ring_reset) begin
            state       <= ST_SYNC;
            phase_valid <= 1'b0;
          end else if (!legal_c) begin
            state       <= ST_FAULT;
            onehot_err  <= 1'b1;
            phase_valid <= 1'b0;
          end else if (ring_in != expected_c) begin
            state       <= ST_FAULT;
            seq_err     <= 1'b1;
            phase_valid <= 1'b0;
          end else begin
            phase_idx   <= set_idx_c;
            phase_valid <= 1'b1;
            if (prev_step && prev_ring[word_size-1]) begin
              wrap_pulse <= 1'b1;
              rev_count  <= rev_count + rev_width'(1);
            end
          end
        end

        ST_FAULT: begin
          phase_valid <= 1'b0;
          if (err_clear) begin
            state <= ST_SYNC;
`ifdef RING_AUTO_RESYNC_EN
            rs_armed <= 1'b0;
          end else if (legal_c) begin
            // Second legal sample in sequence with the first re-enters tracking.
            if (rs_armed && (ring_in == rs_expected_c)) begin
              state       <= ST_TRACK;
              phase_idx   <= set_idx_c;
              phase_valid <= 1'b1;
              prev_ring   <= ring_in;
              prev_step   <= ring_step;
              rs_armed    <= 1'b0;
            end else begin
              rs_armed <= 1'b1;
              rs_ring  <= ring_in;
              rs_step  <= ring_step;
            end
          end else begin
            rs_armed <= 1'b0;
`endif
          end
        end

        default: begin
          state       <= ST_SYNC;
          phase_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
